// File: rtl/timer_seq.sv
// Compare-value sequencer: streams table words into the timer's CMPO register on each overflow.
// Optional macro TIMER_SEQ_REPEAT_EN enables a bounded pass count (SEQ_CTRL.rep) in loop mode.
module timer_seq #(
    parameter int          DEPTH         = 8,
    parameter logic [7:0]  TMR_CMPO_ADDR = 8'h04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    input  logic [7:0]  cpu_t_waddr_i,
    input  logic [31:0] cpu_t_data_i,
    input  logic [3:0]  cpu_t_sel_i,
    input  logic        cpu_t_we_i,
    output logic [7:0]  tmr_waddr_o,
    output logic [31:0] tmr_data_o,
    output logic [3:0]  tmr_sel_o,
    output logic        tmr_we_o,
    input  logic        timer_of_i,
    output logic        irq_seq_o
);
    localparam int         IW       = $clog2(DEPTH);
    localparam logic [3:0] IDX_MASK = 4'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic          en, loop_m, irq_en, done, overrun;
    logic [IW-1:0] last, idx;
    logic [31:0]   tab [DEPTH];
    logic [7:0]    rep_rd;
`ifdef TIMER_SEQ_REPEAT_EN
    logic [7:0]    rep, pass;
`endif

    logic ctrl_we, stat_we, tab_we, grant, wait_of, wrap, finish, unused;
    logic [31:0] rdata;

    // Byte selects are ignored: every config write is a full word.
    assign unused = ^sel_i;

    function automatic logic tab_hit(input logic [7:0] a);
        return (a[7:6] == 2'b01) && (a[1:0] == 2'b00) && ((a[5:2] & ~IDX_MASK) == 4'd0);
    endfunction

    assign ctrl_we = we_i && (waddr_i == 8'h00);
    assign stat_we = we_i && (waddr_i == 8'h04);
    assign tab_we  = we_i && tab_hit(waddr_i);
    assign grant   = (state == S_LOAD) && !cpu_t_we_i;
    assign wait_of = (state == S_WAIT) && timer_of_i;

`ifdef TIMER_SEQ_REPEAT_EN
    assign wrap   = loop_m && (pass != rep);
    assign rep_rd = rep;
`else
    assign wrap   = loop_m;
    assign rep_rd = 8'd0;
`endif
    // A simultaneous SEQ_CTRL write takes over the FSM, so the sequence does not complete.
    assign finish = wait_of && (idx == last) && !wrap && !ctrl_we;

    // CPU owns the timer port whenever it writes; the sequencer write simply waits in LOAD.
    always_comb begin
        tmr_we_o    = 1'b0;
        tmr_waddr_o = cpu_t_waddr_i;
        tmr_data_o  = cpu_t_data_i;
        tmr_sel_o   = cpu_t_sel_i;
        if (rst_n) begin
            if (cpu_t_we_i) begin
                tmr_we_o = 1'b1;
            end else if (state == S_LOAD) begin
                tmr_we_o    = 1'b1;
                tmr_waddr_o = TMR_CMPO_ADDR;
                tmr_data_o  = tab[idx];
                tmr_sel_o   = 4'hF;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (raddr_i == 8'h00)
            rdata = {16'd0, rep_rd, 4'(last), 1'b0, irq_en, loop_m, en};
        else if (raddr_i == 8'h04)
            rdata = {20'd0, 4'(idx), 5'd0, overrun, done, (state != S_IDLE)};
        else if (tab_hit(raddr_i))
            rdata = tab[raddr_i[IW+1:2]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            en        <= 1'b0;
            loop_m    <= 1'b0;
            irq_en    <= 1'b0;
            last      <= '0;
            idx       <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            data_o    <= 32'd0;
            irq_seq_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tab[i] <= 32'd0;
`ifdef TIMER_SEQ_REPEAT_EN
            rep       <= 8'd0;
            pass      <= 8'd0;
`endif
        end else begin
            if (rd_i) data_o <= rdata;
            if (tab_we) tab[waddr_i[IW+1:2]] <= data_i;

            irq_seq_o <= finish && irq_en;
            // Hardware set beats a same-cycle write-1-to-clear.
            done    <= finish || (done && !(stat_we && data_i[1]));
            overrun <= ((state == S_LOAD) && timer_of_i) || (overrun && !(stat_we && data_i[2]));

            case (state)
                S_LOAD: if (grant) state <= S_WAIT;
                S_WAIT: if (wait_of) begin
                    if (idx != last) begin
                        idx   <= idx + 1'b1;
                        state <= S_LOAD;
                    end else if (wrap) begin
                        idx   <= '0;
                        state <= S_LOAD;
`ifdef TIMER_SEQ_REPEAT_EN
                        pass  <= pass + 8'd1;
`endif
                    end else begin
                        en    <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (ctrl_we) begin
                en     <= data_i[0];
                loop_m <= data_i[1];
                irq_en <= data_i[2];
                last   <= data_i[4 +: IW];
`ifdef TIMER_SEQ_REPEAT_EN
                rep    <= data_i[15:8];
                pass   <= 8'd0;
`endif
                if (data_i[0]) begin
                    state <= S_LOAD;
                    idx   <= '0;
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_timer_seq.sv
// Directed bench for timer_seq: a queue of expected timer writes plus literal register checks.
module tb_timer_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  waddr_i, raddr_i, cpu_t_waddr_i, tmr_waddr_o;
    logic [31:0] data_i, data_o, cpu_t_data_i, tmr_data_o;
    logic [3:0]  sel_i, cpu_t_sel_i, tmr_sel_o;
    logic        we_i, rd_i, cpu_t_we_i, tmr_we_o, timer_of_i, irq_seq_o;

    always #5 clk = ~clk;

    timer_seq #(.DEPTH(8), .TMR_CMPO_ADDR(8'h04)) dut (
        .clk(clk), .rst_n(rst_n),
        .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
        .cpu_t_waddr_i(cpu_t_waddr_i), .cpu_t_data_i(cpu_t_data_i),
        .cpu_t_sel_i(cpu_t_sel_i), .cpu_t_we_i(cpu_t_we_i),
        .tmr_waddr_o(tmr_waddr_o), .tmr_data_o(tmr_data_o),
        .tmr_sel_o(tmr_sel_o), .tmr_we_o(tmr_we_o),
        .timer_of_i(timer_of_i), .irq_seq_o(irq_seq_o)
    );

    int checks = 0, errors = 0, irq_cnt = 0, cpu_fwd = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_front, rv;
    logic [31:0] tv [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every timer-port cycle is either a forwarded CPU write or the next expected table word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (irq_seq_o) irq_cnt++;
            if (cpu_t_we_i) begin
                cpu_fwd++;
                chk("cpu_fwd_we", {31'd0, tmr_we_o}, 32'd1);
                chk("cpu_fwd_addr", {24'd0, tmr_waddr_o}, {24'd0, cpu_t_waddr_i});
                chk("cpu_fwd_data", tmr_data_o, cpu_t_data_i);
                chk("cpu_fwd_sel", {28'd0, tmr_sel_o}, {28'd0, cpu_t_sel_i});
            end else if (tmr_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_seq_write: got data %h, expected no write", tmr_data_o);
                end else begin
                    exp_front = exp_q.pop_front();
                    chk("seq_addr", {24'd0, tmr_waddr_o}, 32'h04);
                    chk("seq_sel", {28'd0, tmr_sel_o}, 32'hF);
                    chk("seq_data", tmr_data_o, exp_front);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        waddr_i = a; data_i = d; we_i = 1'b1;
        cyc();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        raddr_i = a; rd_i = 1'b1;
        cyc();
        rd_i = 1'b0;
        d = data_o;
    endtask

    task automatic pulse();
        timer_of_i = 1'b1;
        cyc();
        timer_of_i = 1'b0;
    endtask

    initial begin
        tv[0] = 32'h0010_0005; tv[1] = 32'h0020_0008; tv[2] = 32'h0030_000C;
        rst_n = 1'b0; waddr_i = '0; data_i = '0; sel_i = 4'hF; we_i = 1'b0;
        raddr_i = '0; rd_i = 1'b0; cpu_t_waddr_i = '0; cpu_t_data_i = '0;
        cpu_t_sel_i = '0; cpu_t_we_i = 1'b0; timer_of_i = 1'b0;
        cyc(3);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_tmr_we", {31'd0, tmr_we_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_seq_o}, 32'd0);
        rst_n = 1'b1;
        cyc();
        rd(8'h00, rv); chk("rst_ctrl", rv, 32'd0);
        rd(8'h04, rv); chk("rst_stat", rv, 32'd0);

        for (int i = 0; i < 3; i++) wr(8'(8'h40 + 4 * i), tv[i]);
        rd(8'h48, rv); chk("tab2_readback", rv, 32'h0030_000C);
        raddr_i = 8'h00;
        cyc();
        chk("data_o_hold", data_o, 32'h0030_000C);
        rd(8'h08, rv); chk("unmapped_08", rv, 32'd0);
        rd(8'h60, rv); chk("unmapped_past_depth", rv, 32'd0);
        wr(8'h00, 32'h0000_00F0);
        rd(8'h00, rv); chk("last_masked", rv, 32'h0000_0070);

        // One-shot sequence over entries 0..2 with interrupt.
        exp_q.push_back(tv[0]);
        wr(8'h00, 32'h0000_0025);
        cyc(3);
        for (int p = 0; p < 3; p++) begin
            if (p < 2) exp_q.push_back(tv[p + 1]);
            pulse();
            if (p < 2) cyc(3);
        end
        chk("irq_after_last", {31'd0, irq_seq_o}, 32'd1);
        cyc();
        chk("irq_one_cycle", {31'd0, irq_seq_o}, 32'd0);
        rd(8'h04, rv); chk("oneshot_stat", rv, 32'h0000_0202);
        rd(8'h00, rv); chk("oneshot_ctrl", rv, 32'h0000_0024);
        chk("oneshot_drain", exp_q.size(), 32'd0);
        chk("oneshot_irq_cnt", irq_cnt, 32'd1);
        wr(8'h04, 32'h0000_0002);
        rd(8'h04, rv); chk("done_cleared", rv, 32'h0000_0200);

        // Looping sequence, no interrupt.
        exp_q.push_back(tv[0]);
        wr(8'h00, 32'h0000_0023);
        cyc(3);
        for (int p = 1; p <= 7; p++) begin
            exp_q.push_back(tv[p % 3]);
            pulse();
            cyc(3);
        end
        rd(8'h04, rv); chk("loop_stat", rv, 32'h0000_0101);
        chk("loop_drain", exp_q.size(), 32'd0);
        chk("loop_no_irq", irq_cnt, 32'd1);

        // CPU holds the port for 4 cycles while entry 2 is pending.
        cpu_fwd = 0;
        exp_q.push_back(tv[2]);
        cpu_t_waddr_i = 8'h00; cpu_t_sel_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cpu_t_data_i = 32'hC0DE_0000 + 32'(k);
            cpu_t_we_i = 1'b1;
            timer_of_i = (k == 0);
            cyc();
        end
        cpu_t_we_i = 1'b0; timer_of_i = 1'b0;
        cyc(3);
        chk("arb_cpu_count", cpu_fwd, 32'd4);
        chk("arb_seq_drain", exp_q.size(), 32'd0);

        // Overflow while LOAD is blocked by the CPU: overrun, idx held.
        exp_q.push_back(tv[0]);
        for (int k = 0; k < 2; k++) begin
            cpu_t_data_i = 32'hBEEF_0000 + 32'(k);
            cpu_t_we_i = 1'b1;
            timer_of_i = 1'b1;
            cyc();
        end
        cpu_t_we_i = 1'b0; timer_of_i = 1'b0;
        cyc(3);
        chk("ovr_cpu_count", cpu_fwd, 32'd6);
        chk("ovr_drain", exp_q.size(), 32'd0);
        rd(8'h04, rv); chk("ovr_stat", rv, 32'h0000_0005);
        wr(8'h04, 32'h0000_0004);
        rd(8'h04, rv); chk("ovr_cleared", rv, 32'h0000_0001);

        // Cancel mid-sequence at idx=1.
        exp_q.push_back(tv[1]);
        pulse();
        cyc(3);
        wr(8'h00, 32'h0000_0000);
        rd(8'h04, rv); chk("cancel_stat", rv, 32'h0000_0100);
        pulse(); cyc(2); pulse(); cyc(2);
        chk("cancel_no_writes", exp_q.size(), 32'd0);
        chk("cancel_no_irq", irq_cnt, 32'd1);

        wr(8'h40, 32'h0000_0003);
`ifdef TIMER_SEQ_REPEAT_EN
        exp_q.push_back(32'h0000_0003);
        wr(8'h00, 32'h0000_0107);
        cyc(3);
        exp_q.push_back(32'h0000_0003);
        pulse();
        cyc(3);
        pulse();
        chk("rep_irq", {31'd0, irq_seq_o}, 32'd1);
        cyc();
        rd(8'h04, rv); chk("rep_stat", rv, 32'h0000_0002);
        rd(8'h00, rv); chk("rep_ctrl", rv, 32'h0000_0106);
        chk("rep_drain", exp_q.size(), 32'd0);
        chk("rep_irq_cnt", irq_cnt, 32'd2);
`else
        exp_q.push_back(32'h0000_0003);
        wr(8'h00, 32'h0000_0127);
        cyc(3);
        rd(8'h00, rv); chk("norep_ctrl", rv, 32'h0000_0027);
        wr(8'h00, 32'h0000_0000);
        cyc(2);
        chk("norep_drain", exp_q.size(), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
